// File: rtl/count_stimulus_gen_pkg.sv
// Shared types and helpers for the count_stimulus_gen command-to-En-pulse generator.
package count_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } stim_state_e;

  localparam int unsigned GAP_TIMER_W = 4;

  // Shift amount for the Slt=1 prescale; only 1, 2 and 4 are legal.
  function automatic int unsigned div_log2(input int unsigned div);
    case (div)
      2:       return 1;
      4:       return 2;
      default: return 0;
    endcase
  endfunction

  // Issued/total need two extra bits so that count*DIV never overflows.
  function automatic int unsigned total_w(input int unsigned cnt_w);
    return cnt_w + 2;
  endfunction

endpackage

// File: rtl/count_stimulus_gen_if.sv
// Command and counter-drive signals of count_stimulus_gen.
// Optional Abort/Aborted pair exists only with COUNT_STIM_ABORT_EN defined.
interface count_stimulus_gen_if #(
  parameter int unsigned CNT_W = 16
);
  logic             Cmd_valid;
  logic             Cmd_ready;
  logic             Cmd_slt;
  logic [CNT_W-1:0] Cmd_count;
  logic             En;
  logic             Slt;
  logic             Busy;
  logic             Done;
  logic [CNT_W+1:0] Issued;
`ifdef COUNT_STIM_ABORT_EN
  logic             Abort;
  logic             Aborted;

  modport master (
    output Cmd_valid, Cmd_slt, Cmd_count, Abort,
    input  Cmd_ready, En, Slt, Busy, Done, Issued, Aborted
  );
  modport slave (
    input  Cmd_valid, Cmd_slt, Cmd_count, Abort,
    output Cmd_ready, En, Slt, Busy, Done, Issued, Aborted
  );
`else
  modport master (
    output Cmd_valid, Cmd_slt, Cmd_count,
    input  Cmd_ready, En, Slt, Busy, Done, Issued
  );
  modport slave (
    input  Cmd_valid, Cmd_slt, Cmd_count,
    output Cmd_ready, En, Slt, Busy, Done, Issued
  );
`endif
endinterface

// File: rtl/count_stimulus_gen_gap_timer.sv
// Loadable 4-bit down-counter with zero flag; times the idle cycles between En pulses.
module gap_timer
  import count_stim_pkg::*;
(
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   load_i,
  input  logic [GAP_TIMER_W-1:0] load_val_i,
  input  logic                   dec_i,
  output logic                   zero_o
);

  logic [GAP_TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - GAP_TIMER_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/count_stimulus_gen.sv
// Turns one (mode, count) command into a stream of En pulses with Slt held.
// Optional abort support is enabled by defining COUNT_STIM_ABORT_EN.
module count_stimulus_gen
  import count_stim_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV   = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic                Clk,
  input  logic                Reset,
  count_stimulus_gen_if.slave bus
);

  localparam int unsigned TOTAL_W  = total_w(CNT_W);
  localparam int unsigned DIV_LOG2 = div_log2(DIV);
  // The timer is loaded with GAP-1 and returns to RUN on zero, which gives
  // exactly GAP idle cycles (same as counting GAP down to 1).
  localparam logic [GAP_TIMER_W-1:0] GAP_LOAD =
    (GAP > 0) ? GAP_TIMER_W'(GAP - 1) : '0;

  stim_state_e        state_q, state_d;
  logic               slt_q, slt_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [TOTAL_W-1:0] issued_q, issued_d;
  logic               en;
  logic               gap_load, gap_dec, gap_zero;
  logic               busy;
  logic               abort;
`ifdef COUNT_STIM_ABORT_EN
  logic               aborted_q, aborted_d;
  assign abort = bus.Abort;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    slt_d    = slt_q;
    total_d  = total_q;
    issued_d = issued_q;
    en       = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
`ifdef COUNT_STIM_ABORT_EN
    aborted_d = aborted_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.Cmd_valid) begin
          slt_d    = bus.Cmd_slt;
          total_d  = bus.Cmd_slt ? (TOTAL_W'(bus.Cmd_count) << DIV_LOG2)
                                 : TOTAL_W'(bus.Cmd_count);
          issued_d = '0;
`ifdef COUNT_STIM_ABORT_EN
          aborted_d = 1'b0;
`endif
          state_d  = (total_d == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_DONE;
`ifdef COUNT_STIM_ABORT_EN
          aborted_d = 1'b1;
`endif
        end else begin
          en       = 1'b1;
          issued_d = issued_q + TOTAL_W'(1);
          if (issued_d == total_q) begin
            state_d = ST_DONE;
          end else if (GAP > 0) begin
            state_d  = ST_GAP;
            gap_load = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_DONE;
`ifdef COUNT_STIM_ABORT_EN
          aborted_d = 1'b1;
`endif
        end else if (gap_zero) begin
          state_d = ST_RUN;
        end else begin
          gap_dec = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      slt_q    <= 1'b0;
      total_q  <= '0;
      issued_q <= '0;
`ifdef COUNT_STIM_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      slt_q    <= slt_d;
      total_q  <= total_d;
      issued_q <= issued_d;
`ifdef COUNT_STIM_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  gap_timer u_gap_timer (
    .Clk        (Clk),
    .Reset      (Reset),
    .load_i     (gap_load),
    .load_val_i (GAP_LOAD),
    .dec_i      (gap_dec),
    .zero_o     (gap_zero)
  );

  assign busy          = (state_q != ST_IDLE);
  assign bus.Busy      = busy;
  assign bus.Cmd_ready = ~busy;
  assign bus.En        = en;
  assign bus.Slt       = busy & slt_q;
  assign bus.Done      = (state_q == ST_DONE);
  assign bus.Issued    = issued_q;
`ifdef COUNT_STIM_ABORT_EN
  assign bus.Aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_count_stimulus_gen.sv
// Directed bench for count_stimulus_gen: one instance with GAP=0, one with GAP=2.
module tb_count_stimulus_gen;

  logic Clk = 1'b0;
  logic Reset;
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  always #5 Clk = ~Clk;

  count_stimulus_gen_if #(.CNT_W(16)) b0 ();
  count_stimulus_gen_if #(.CNT_W(16)) b2 ();

  count_stimulus_gen #(.CNT_W(16), .DIV(4), .GAP(0)) dut0 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (b0.slave)
  );

  count_stimulus_gen #(.CNT_W(16), .DIV(4), .GAP(2)) dut2 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (b2.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset        = 1'b1;
    b0.Cmd_valid = 1'b0; b0.Cmd_slt = 1'b0; b0.Cmd_count = '0;
    b2.Cmd_valid = 1'b0; b2.Cmd_slt = 1'b0; b2.Cmd_count = '0;
`ifdef COUNT_STIM_ABORT_EN
    b0.Abort = 1'b0;
    b2.Abort = 1'b0;
`endif
    tick();
    tick();
    chk("rst_ready",  b0.Cmd_ready, 1);
    chk("rst_en",     b0.En,        0);
    chk("rst_busy",   b0.Busy,      0);
    chk("rst_done",   b0.Done,      0);
    chk("rst_slt",    b0.Slt,       0);
    chk("rst_issued", b0.Issued,    0);
    chk("rst_ready2", b2.Cmd_ready, 1);
    Reset = 1'b0;
    tick();

    // Direct count of 5, no gap: En t+1..t+5, Done t+6
    b0.Cmd_valid = 1'b1; b0.Cmd_slt = 1'b0; b0.Cmd_count = 16'd5;
    tick();
    b0.Cmd_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk("t1_en",     b0.En,        1);
      chk("t1_slt",    b0.Slt,       0);
      chk("t1_busy",   b0.Busy,      1);
      chk("t1_ready",  b0.Cmd_ready, 0);
      chk("t1_issued", b0.Issued,    32'(k - 1));
      chk("t1_done",   b0.Done,      0);
      tick();
    end
    chk("t1_done_pulse", b0.Done,   1);
    chk("t1_en_off",     b0.En,     0);
    chk("t1_issued_fin", b0.Issued, 5);
    tick();
    chk("t1_done_clr",   b0.Done,      0);
    chk("t1_ready_back", b0.Cmd_ready, 1);
    chk("t1_issued_hold", b0.Issued,   5);

    // Prescaled count of 3 with DIV=4: 12 pulses, Slt high; busy-time command ignored
    b0.Cmd_valid = 1'b1; b0.Cmd_slt = 1'b1; b0.Cmd_count = 16'd3;
    tick();
    b0.Cmd_valid = 1'b0; b0.Cmd_slt = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      chk("t2_en",  b0.En,  1);
      chk("t2_slt", b0.Slt, 1);
      if (k == 3) begin
        b0.Cmd_valid = 1'b1; b0.Cmd_count = 16'd7;
      end else begin
        b0.Cmd_valid = 1'b0;
      end
      tick();
    end
    chk("t2_done",     b0.Done,   1);
    chk("t2_slt_done", b0.Slt,    1);
    chk("t2_issued",   b0.Issued, 12);
    tick();
    chk("t2_idle_slt", b0.Slt,       0);
    chk("t2_idle_rdy", b0.Cmd_ready, 1);
    chk("t2_issued_h", b0.Issued,    12);

    // Zero count: straight to Done
    b0.Cmd_valid = 1'b1; b0.Cmd_slt = 1'b0; b0.Cmd_count = 16'd0;
    tick();
    b0.Cmd_valid = 1'b0;
    chk("t3_done",   b0.Done,      1);
    chk("t3_en",     b0.En,        0);
    chk("t3_ready",  b0.Cmd_ready, 0);
    chk("t3_issued", b0.Issued,    0);
    tick();
    chk("t3_ready_back", b0.Cmd_ready, 1);
    chk("t3_done_clr",   b0.Done,      0);

    // GAP=2, count 3: En t+1, t+4, t+7; Done t+8
    b2.Cmd_valid = 1'b1; b2.Cmd_slt = 1'b0; b2.Cmd_count = 16'd3;
    tick();
    b2.Cmd_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("t4_en",   b2.En,   (k == 1 || k == 4 || k == 7) ? 1 : 0);
      chk("t4_done", b2.Done, (k == 8) ? 1 : 0);
      chk("t4_busy", b2.Busy, 1);
      tick();
    end
    chk("t4_idle",   b2.Busy,   0);
    chk("t4_issued", b2.Issued, 3);

    // Reset after 2 of 10 pulses
    b0.Cmd_valid = 1'b1; b0.Cmd_slt = 1'b0; b0.Cmd_count = 16'd10;
    tick();
    b0.Cmd_valid = 1'b0;
    chk("t5_en1", b0.En, 1);
    tick();
    chk("t5_en2",     b0.En,     1);
    chk("t5_issued1", b0.Issued, 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("t5_en_off",  b0.En,        0);
    chk("t5_busy",    b0.Busy,      0);
    chk("t5_issued0", b0.Issued,    0);
    chk("t5_nodone",  b0.Done,      0);
    chk("t5_ready",   b0.Cmd_ready, 1);
    tick();
    chk("t5_nodone2", b0.Done, 0);
    b0.Cmd_valid = 1'b1; b0.Cmd_count = 16'd2;
    tick();
    b0.Cmd_valid = 1'b0;
    chk("t5_new_en1", b0.En, 1);
    tick();
    chk("t5_new_en2", b0.En, 1);
    tick();
    chk("t5_new_done",   b0.Done,   1);
    chk("t5_new_issued", b0.Issued, 2);
    tick();

`ifdef COUNT_STIM_ABORT_EN
    // Abort after 4 of 8 pulses
    b0.Abort = 1'b1;
    tick();
    chk("t6_idle_abort_ign", b0.Aborted, 0);
    b0.Abort = 1'b0;
    b0.Cmd_valid = 1'b1; b0.Cmd_slt = 1'b0; b0.Cmd_count = 16'd8;
    tick();
    b0.Cmd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("t6_en", b0.En, 1);
      tick();
    end
    b0.Abort = 1'b1;
    #1;
    chk("t6_en_abort", b0.En,   0);
    chk("t6_no_done",  b0.Done, 0);
    tick();
    b0.Abort = 1'b0;
    chk("t6_done",    b0.Done,    1);
    chk("t6_aborted", b0.Aborted, 1);
    chk("t6_issued",  b0.Issued,  4);
    tick();
    chk("t6_aborted_hold", b0.Aborted, 1);
    chk("t6_idle",         b0.Busy,    0);
    b0.Cmd_valid = 1'b1; b0.Cmd_count = 16'd1;
    tick();
    b0.Cmd_valid = 1'b0;
    chk("t6_aborted_clr", b0.Aborted, 0);
    tick();
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
